// File: rtl/eca_pkg.sv
// Shared encodings for the elementary cellular automaton engine:
// boundary-mode codes and the control FSM state type.
package eca_pkg;

  // Boundary handling for the two out-of-range neighbours
  localparam logic [1:0] BM_PERIODIC = 2'b00;
  localparam logic [1:0] BM_ZERO     = 2'b01;
  localparam logic [1:0] BM_ONE      = 2'b10;
  localparam logic [1:0] BM_REFLECT  = 2'b11;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } eca_state_t;

endpackage

// File: rtl/eca_next.sv
// Combinational next-generation logic for a WIDTH-cell elementary CA.
// Each cell looks up the rule bit selected by {s[i+1], s[i], s[i-1]};
// the two missing edge neighbours come from the boundary mode.
module eca_next
  import eca_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] state,
  input  logic [7:0]       rule_q,
  input  logic [1:0]       bmode_q,
  output logic [WIDTH-1:0] next,
  output logic             same
);

  logic             hi_s;     // virtual neighbour s[WIDTH]
  logic             lo_s;     // virtual neighbour s[-1]
  logic [WIDTH+1:0] ext_s;    // {s[WIDTH], s[WIDTH-1:0], s[-1]}
  logic [2:0]       nbhd_s;

  // Select the virtual edge neighbours for the current boundary mode
  always_comb begin
    hi_s = 1'b0;
    lo_s = 1'b0;
    case (bmode_q)
      BM_PERIODIC: begin
        hi_s = state[0];
        lo_s = state[WIDTH-1];
      end
      BM_ZERO: begin
        hi_s = 1'b0;
        lo_s = 1'b0;
      end
      BM_ONE: begin
        hi_s = 1'b1;
        lo_s = 1'b1;
      end
      BM_REFLECT: begin
        hi_s = state[WIDTH-1];
        lo_s = state[0];
      end
      default: begin
        hi_s = 1'b0;
        lo_s = 1'b0;
      end
    endcase
  end

  assign ext_s = {hi_s, state, lo_s};

  // Look up every cell's next value; ext_s[i +: 3] is {s[i+1], s[i], s[i-1]}
  always_comb begin
    next   = '0;
    nbhd_s = 3'b000;
    for (int i = 0; i < WIDTH; i++) begin
      nbhd_s  = ext_s[i +: 3];
      next[i] = rule_q[nbhd_s];
    end
  end

  assign same = (next == state);

endmodule

// File: rtl/eca_engine.sv
// Elementary cellular automaton engine: a WIDTH-cell automaton with a
// run-time rule and boundary mode, evolved under a load/start/step/stop
// control FSM with a saturating generation counter.
module eca_engine
  import eca_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic [7:0]       rule,
  input  logic [1:0]       bmode,
  input  logic [CNT_W-1:0] max_gen,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  output logic [WIDTH-1:0] state,
  output logic [CNT_W-1:0] gen,
  output logic             busy,
  output logic             done,
  output logic             stable
);

  eca_state_t       fsm_q;
  logic [WIDTH-1:0] state_q;
  logic [CNT_W-1:0] gen_q;
  logic [CNT_W-1:0] max_q;
  logic [7:0]       rule_q;
  logic [1:0]       bmode_q;
  logic             busy_q;
  logic             done_q;
  logic             stable_q;

  logic [WIDTH-1:0] state_d;    // next generation
  logic             same_d;     // next generation equals current one
  logic [CNT_W-1:0] gen_inc_s;
  logic             gen_sat_s;  // counter already at all-ones
  logic             last_s;     // this update reaches the limit or saturates

  eca_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .state  (state_q),
    .rule_q (rule_q),
    .bmode_q(bmode_q),
    .next   (state_d),
    .same   (same_d)
  );

  assign gen_inc_s = gen_q + CNT_W'(1);
  assign gen_sat_s = &gen_q;
  assign last_s    = ((max_q != '0) && (gen_inc_s == max_q)) || (&gen_inc_s);

  // Control FSM with all outputs registered; priority res > load > start > step > stop
  always_ff @(posedge clk) begin
    if (res) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      gen_q    <= '0;
      max_q    <= '0;
      rule_q   <= 8'h00;
      bmode_q  <= BM_PERIODIC;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stable_q <= 1'b0;
    end else if (load) begin
      fsm_q    <= IDLE;
      state_q  <= init;
      rule_q   <= rule;
      bmode_q  <= bmode;
      gen_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE, HALT: begin
          if (start) begin
            max_q  <= max_gen;
            done_q <= 1'b0;
            busy_q <= 1'b1;
            fsm_q  <= RUN;
          end else if (step) begin
            state_q  <= state_d;
            if (!gen_sat_s) begin
              gen_q <= gen_inc_s;
            end
            stable_q <= same_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            fsm_q    <= HALT;
          end
        end
        RUN: begin
          if (stop) begin
            // Halt immediately, leaving the current generation untouched
            done_q <= 1'b1;
            busy_q <= 1'b0;
            fsm_q  <= HALT;
          end else if (same_d) begin
            // Fixed point: nothing more to compute
            stable_q <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            fsm_q    <= HALT;
          end else if (gen_sat_s) begin
            // Counter cannot advance any further, so the run cannot either
            stable_q <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            fsm_q    <= HALT;
          end else begin
            state_q  <= state_d;
            gen_q    <= gen_inc_s;
            stable_q <= 1'b0;
            if (last_s) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              fsm_q  <= HALT;
            end
          end
        end
        default: begin
          fsm_q  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign state  = state_q;
  assign gen    = gen_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign stable = stable_q;

endmodule

// File: tb/tb_eca_engine.sv
// Bench for eca_engine: three instances (20 cells, 8 cells, and a
// 5-cell one with a 4-bit counter to reach saturation), a behavioural
// reference model per instance, directed plan checks and random traffic.
module tb_eca_engine;

  localparam int WS[3] = '{20, 8, 5};
  localparam int CW[3] = '{16, 16, 4};

  typedef struct {
    logic [31:0] st;
    logic [15:0] gen;
    bit          run;
    bit          done;
    bit          stable;
    logic [7:0]  rule;
    logic [1:0]  bm;
    logic [15:0] maxg;
  } mdl_t;

  logic        clk;
  logic        res;
  logic        ld[3], sa[3], sp[3], so[3];
  logic [31:0] ini[3];
  logic [7:0]  rl[3];
  logic [1:0]  bm[3];
  logic [15:0] mg[3];

  logic [19:0] s0;
  logic [7:0]  s1;
  logic [4:0]  s2;
  logic [15:0] g0, g1;
  logic [3:0]  g2;
  logic        bz[3], dn[3], sb[3];

  logic [31:0] act_st[3];
  logic [15:0] act_gen[3];

  mdl_t m[3];
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  eca_engine #(.WIDTH(20), .CNT_W(16)) u0 (
    .clk(clk), .res(res), .load(ld[0]), .init(ini[0][19:0]), .rule(rl[0]),
    .bmode(bm[0]), .max_gen(mg[0]), .start(sa[0]), .step(sp[0]), .stop(so[0]),
    .state(s0), .gen(g0), .busy(bz[0]), .done(dn[0]), .stable(sb[0]));

  eca_engine #(.WIDTH(8), .CNT_W(16)) u1 (
    .clk(clk), .res(res), .load(ld[1]), .init(ini[1][7:0]), .rule(rl[1]),
    .bmode(bm[1]), .max_gen(mg[1]), .start(sa[1]), .step(sp[1]), .stop(so[1]),
    .state(s1), .gen(g1), .busy(bz[1]), .done(dn[1]), .stable(sb[1]));

  eca_engine #(.WIDTH(5), .CNT_W(4)) u2 (
    .clk(clk), .res(res), .load(ld[2]), .init(ini[2][4:0]), .rule(rl[2]),
    .bmode(bm[2]), .max_gen(mg[2][3:0]), .start(sa[2]), .step(sp[2]), .stop(so[2]),
    .state(s2), .gen(g2), .busy(bz[2]), .done(dn[2]), .stable(sb[2]));

  assign act_st[0]  = {12'd0, s0};
  assign act_st[1]  = {24'd0, s1};
  assign act_st[2]  = {27'd0, s2};
  assign act_gen[0] = g0;
  assign act_gen[1] = g1;
  assign act_gen[2] = {12'd0, g2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference next generation straight from the rule table definition
  function automatic logic [31:0] ca_next(logic [31:0] s, int w, logic [7:0] r, logic [1:0] b);
    logic [31:0] n;
    logic        l, c, rr;
    n = 32'd0;
    for (int i = 0; i < w; i++) begin
      c = s[i];
      if (i == w - 1)
        l = (b == 2'd0) ? s[0] : (b == 2'd1) ? 1'b0 : (b == 2'd2) ? 1'b1 : s[w-1];
      else
        l = s[i+1];
      if (i == 0)
        rr = (b == 2'd0) ? s[w-1] : (b == 2'd1) ? 1'b0 : (b == 2'd2) ? 1'b1 : s[0];
      else
        rr = s[i-1];
      n[i] = r[{l, c, rr}];
    end
    return n;
  endfunction

  // One clock edge of the behavioural model
  function automatic mdl_t mstep(mdl_t cur, int w, int cw, bit rs, bit l, bit st, bit sx, bit sto,
                                 logic [31:0] iv, logic [7:0] r, logic [1:0] b, logic [15:0] mx);
    mdl_t        n;
    logic [31:0] nx;
    logic [15:0] top;
    n   = cur;
    top = 16'((32'd1 << cw) - 32'd1);
    nx  = ca_next(cur.st, w, cur.rule, cur.bm);
    if (rs) begin
      n = '{default: 0};
    end else if (l) begin
      n.st = iv & ((32'd1 << w) - 32'd1);
      n.rule = r; n.bm = b; n.gen = 16'd0;
      n.run = 1'b0; n.done = 1'b0; n.stable = 1'b0;
    end else if (!cur.run && st) begin
      n.maxg = mx & top; n.done = 1'b0; n.run = 1'b1;
    end else if (!cur.run && sx) begin
      n.st = nx;
      n.gen = (cur.gen == top) ? cur.gen : cur.gen + 16'd1;
      n.stable = (nx == cur.st); n.done = 1'b1;
    end else if (cur.run) begin
      if (sto) begin
        n.run = 1'b0; n.done = 1'b1;
      end else if (nx == cur.st) begin
        n.run = 1'b0; n.done = 1'b1; n.stable = 1'b1;
      end else if (cur.gen == top) begin
        n.run = 1'b0; n.done = 1'b1; n.stable = 1'b0;
      end else begin
        n.st = nx; n.gen = cur.gen + 16'd1; n.stable = 1'b0;
        if ((n.maxg != 16'd0 && n.gen == n.maxg) || n.gen == top) begin
          n.run = 1'b0; n.done = 1'b1;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%h expected=%h", nm, k, act, exp);
    end
  endtask

  // Advance one clock edge: model computed from pre-edge inputs, DUT samples the same
  task automatic tick();
    mdl_t nx[3];
    for (int k = 0; k < 3; k++)
      nx[k] = mstep(m[k], WS[k], CW[k], res, ld[k], sa[k], sp[k], so[k], ini[k], rl[k], bm[k], mg[k]);
    @(posedge clk);
    for (int k = 0; k < 3; k++) m[k] = nx[k];
    #1;
  endtask

  task automatic do_load(int k, logic [31:0] v, logic [7:0] r, logic [1:0] b);
    ld[k] = 1'b1; ini[k] = v; rl[k] = r; bm[k] = b;
    tick();
    ld[k] = 1'b0;
  endtask

  task automatic do_start(int k, logic [15:0] mx);
    sa[k] = 1'b1; mg[k] = mx;
    tick();
    sa[k] = 1'b0;
  endtask

  task automatic do_step(int k);
    sp[k] = 1'b1;
    tick();
    sp[k] = 1'b0;
  endtask

  task automatic pin(string nm, int k, logic [31:0] st, logic [15:0] g, bit b, bit d, bit s);
    chk({nm, "_state"}, k, act_st[k], st);
    chk({nm, "_gen"}, k, {16'd0, act_gen[k]}, {16'd0, g});
    chk({nm, "_busy"}, k, {31'd0, bz[k]}, {31'd0, b});
    chk({nm, "_done"}, k, {31'd0, dn[k]}, {31'd0, d});
    chk({nm, "_stable"}, k, {31'd0, sb[k]}, {31'd0, s});
    chk({nm, "_model_state"}, k, m[k].st, st);
    chk({nm, "_model_gen"}, k, {16'd0, m[k].gen}, {16'd0, g});
  endtask

  // Every-cycle comparison of all instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("cyc_state", k, act_st[k], m[k].st);
        chk("cyc_gen", k, {16'd0, act_gen[k]}, {16'd0, m[k].gen});
        chk("cyc_busy", k, {31'd0, bz[k]}, {31'd0, m[k].run});
        chk("cyc_done", k, {31'd0, dn[k]}, {31'd0, m[k].done});
        chk("cyc_stable", k, {31'd0, sb[k]}, {31'd0, m[k].stable});
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      m[k] = '{default: 0};
      ld[k] = 1'b0; sa[k] = 1'b0; sp[k] = 1'b0; so[k] = 1'b0;
      ini[k] = 32'd0; rl[k] = 8'd0; bm[k] = 2'd0; mg[k] = 16'd0;
    end
    res = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    res = 1'b0;
    for (int k = 0; k < 3; k++) pin("reset", k, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);

    // Rule 184, periodic, single step
    do_load(0, 32'habcde, 8'd184, 2'b00);
    do_step(0);
    pin("r184_step", 0, 32'h57abd, 16'd1, 1'b0, 1'b1, 1'b0);
    chk("r184_pop", 0, $countones(act_st[0]), 32'd13);

    // Rule 0 free run: one generation to all-zero, then fixed point
    do_load(0, 32'habcde, 8'd0, 2'b00);
    do_start(0, 16'd0);
    chk("r0_busy", 0, {31'd0, bz[0]}, 32'd1);
    tick();
    pin("r0_gen1", 0, 32'd0, 16'd1, 1'b1, 1'b0, 1'b0);
    tick();
    pin("r0_fixed", 0, 32'd0, 16'd1, 1'b0, 1'b1, 1'b1);

    // Rule 170 fixed-0 shift with a limit of 4
    do_load(1, 32'h01, 8'd170, 2'b01);
    do_start(1, 16'd4);
    for (int g = 1; g <= 4; g++) begin
      tick();
      chk("r170_shift", 1, act_st[1], 32'h01 << g);
    end
    pin("r170_limit", 1, 32'h10, 16'd4, 1'b0, 1'b1, 1'b0);

    // Boundary modes, one step each
    do_load(1, 32'h80, 8'd170, 2'b00);
    do_step(1);
    chk("bm_periodic", 1, act_st[1], 32'h01);
    do_load(1, 32'h00, 8'd170, 2'b10);
    do_step(1);
    chk("bm_one", 1, act_st[1], 32'h01);
    do_load(1, 32'h80, 8'd170, 2'b11);
    do_step(1);
    chk("bm_reflect", 1, act_st[1], 32'h00);

    // Mid-run stop, restart, then reset
    do_load(0, 32'habcde, 8'd184, 2'b00);
    do_start(0, 16'd0);
    repeat (3) tick();
    so[0] = 1'b1;
    tick();
    so[0] = 1'b0;
    chk("stop_gen", 0, {16'd0, act_gen[0]}, 32'd3);
    chk("stop_done", 0, {31'd0, dn[0]}, 32'd1);
    tick();
    chk("stop_hold", 0, {16'd0, act_gen[0]}, 32'd3);
    do_start(0, 16'd0);
    tick();
    chk("restart_gen", 0, {16'd0, act_gen[0]}, 32'd4);
    res = 1'b1;
    tick();
    res = 1'b0;
    pin("midrun_res", 0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);

    // Load and start together while running: load wins
    do_load(0, 32'habcde, 8'd184, 2'b00);
    do_start(0, 16'd0);
    tick();
    ld[0] = 1'b1; sa[0] = 1'b1; ini[0] = 32'h12345;
    tick();
    ld[0] = 1'b0; sa[0] = 1'b0;
    pin("load_wins", 0, 32'h12345, 16'd0, 1'b0, 1'b0, 1'b0);

    // Counter saturation on the 4-bit instance (rotating pattern never settles)
    do_load(2, 32'h01, 8'd170, 2'b00);
    do_start(2, 16'd0);
    repeat (15) tick();
    pin("sat_halt", 2, 32'h01, 16'd15, 1'b0, 1'b1, 1'b0);
    do_step(2);
    pin("sat_step", 2, 32'h02, 16'd15, 1'b0, 1'b1, 1'b0);
    do_start(2, 16'd0);
    tick();
    pin("sat_restart", 2, 32'h02, 16'd15, 1'b0, 1'b1, 1'b0);

    // Random traffic checked by the every-cycle compare
    for (int c = 0; c < 4000; c++) begin
      res = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < 3; k++) begin
        int r;
        r = $urandom_range(0, 99);
        ld[k] = (r < 3);
        sa[k] = (r >= 3 && r < 8);
        sp[k] = (r >= 8 && r < 13);
        so[k] = (r >= 13 && r < 15);
        if ($urandom_range(0, 9) == 0) so[k] = 1'b1;
        ini[k] = $urandom;
        rl[k]  = 8'($urandom);
        bm[k]  = 2'($urandom);
        mg[k]  = 16'($urandom_range(0, 24));
      end
      tick();
    end
    res = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ld[k] = 1'b0; sa[k] = 1'b0; sp[k] = 1'b0; so[k] = 1'b0;
    end
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
